lcs_frame_sender: RTL and testbench

LCS_FRAME_SENDER -- requirements
Module: lcs_frame_sender

---
 rtl/lcs_frame_sender.sv | 162 ++++++++++++++++
 tb/tb_lcs_frame_sender.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcs_frame_sender.sv
// Frame sender: requests FRAME_LEN bytes from the LCS answer stage and serialises them on txd.
// Optional even-parity bit per byte when LCS_PARITY_EN is defined.
module lcs_frame_sender #(
  parameter int FRAME_LEN   = 256,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bitTick,
  input  logic       start,
  input  logic       ack,
  input  logic [7:0] dataIn,
  output logic       req,
  output logic [8:0] addrLCS,
  output logic       txd,
  output logic       busy,
  output logic       frameDone,
  output logic       errFlag
);

`ifdef LCS_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int             TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [8:0]     LAST  = 9'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, LATCH, SHIFT, RELEASE, NEXT} state_t;

  state_t             state_q, state_d;
  logic               ack_s1_q, ack_s2_q;
  logic [8:0]         addr_q, addr_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [NBITS-1:0]   frm_q, frm_d;
  logic [3:0]         bcnt_q, bcnt_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               to_q, to_d;

  // Line image of one byte, shifted out LSB first: start, data, [parity], stop.
  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef LCS_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      addr_q   <= '0;
      tmr_q    <= '0;
      frm_q    <= '0;
      bcnt_q   <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_s1_q <= ack;
      ack_s2_q <= ack_s1_q;
      addr_q   <= addr_d;
      tmr_q    <= tmr_d;
      frm_q    <= frm_d;
      bcnt_q   <= bcnt_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      done_q   <= done_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmr_d   = tmr_q;
    frm_d   = frm_q;
    bcnt_d  = bcnt_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          tmr_d   = TLOAD;
          to_d    = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s2_q) begin
          state_d = LATCH;
        end else if (tmr_q == '0) begin
          // Missing byte: send 0xFF with req already dropped, skip RELEASE.
          frm_d   = frame_of(8'hFF);
          bcnt_d  = 4'(NBITS);
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = SHIFT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      LATCH: begin
        frm_d   = frame_of(dataIn);
        bcnt_d  = 4'(NBITS);
        to_d    = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bitTick) begin
          if (bcnt_q == 4'd0) begin
            state_d = to_q ? NEXT : RELEASE;
          end else begin
            txd_d  = frm_q[0];
            frm_d  = {1'b1, frm_q[NBITS-1:1]};
            bcnt_d = bcnt_q - 4'd1;
          end
        end
      end
      RELEASE: begin
        if (!ack_s2_q) state_d = NEXT;
      end
      NEXT: begin
        if (addr_q == LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + 9'd1;
          tmr_d   = TLOAD;
          to_d    = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req       = (state_q == REQ) || (state_q == LATCH) || ((state_q == SHIFT) && !to_q);
  assign addrLCS   = addr_q;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign frameDone = done_q;
  assign errFlag   = err_q;

endmodule

// File: tb/tb_lcs_frame_sender.sv
// Bench for lcs_frame_sender: behavioural ack responder plus a UART-style line receiver.
// Expected bytes/parity come from the per-address plan; honours LCS_PARITY_EN.
module tb_lcs_frame_sender;
  localparam int FL   = 4;
  localparam int AT   = 64;
  localparam int TICK = 4;
`ifdef LCS_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, bitTick, start, ack;
  logic [7:0] dataIn;
  logic       req, txd, busy, frameDone, errFlag;
  logic [8:0] addrLCS;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcs_frame_sender #(.FRAME_LEN(FL), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .bitTick(bitTick), .start(start), .ack(ack),
    .dataIn(dataIn), .req(req), .addrLCS(addrLCS), .txd(txd), .busy(busy),
    .frameDone(frameDone), .errFlag(errFlag)
  );

  // per-address responder plan
  logic [7:0] p_data[FL];
  int         p_delay[FL];
  bit         p_noack[FL];
  int         p_hold[FL];
  bit         hold_chk = 1'b0;
  int         hold_seen = 0;

  // observations
  logic [7:0] rx_q[$];
  bit         par_q[$];
  bit         stop_q[$];
  int         addr_seq[$];
  int         reqlen_q[$];
  int         done_cnt = 0;
  int         bitpos = 0;
  logic       err_at_start;

  int tick_ph;
  initial begin
    bitTick = 1'b0;
    tick_ph = $urandom_range(0, TICK - 1);
    forever begin
      @(negedge clk);
      tick_ph = (tick_ph + 1) % TICK;
      bitTick = (tick_ph == 0);
    end
  end

  // line receiver
  initial begin : mon
    bit         hunt;
    int         idx;
    logic [10:0] sh;
    logic       prev, line, tk, r;
    hunt = 1'b1; idx = 0; sh = '0; prev = 1'b1;
    forever begin
      @(posedge clk);
      tk = bitTick;
      r  = rst;
      #1;
      line = txd;
      if (frameDone === 1'b1) done_cnt++;
      if (r) begin
        hunt   = 1'b1;
        bitpos = 0;
      end else begin
        if (line !== prev) begin
          tests++;
          if (tk !== 1'b1) begin
            fails++;
            $display("FAIL txd_change_no_tick: txd=%b changed with bitTick=%b at %0t", line, tk, $time);
          end
        end
        tests++;
        if (addrLCS > 9'(FL - 1)) begin
          fails++;
          $display("FAIL addr_bound: addrLCS=%0d max=%0d", addrLCS, FL - 1);
        end
        if (tk) begin
          if (hunt) begin
            if (line == 1'b0) begin
              hunt = 1'b0; idx = 0; bitpos = 1;
            end
          end else begin
            sh[idx] = line;
            idx++;
            bitpos++;
            if (idx == NB - 1) begin
              rx_q.push_back(sh[7:0]);
              stop_q.push_back(sh[NB-2]);
              par_q.push_back(sh[8]);
              hunt   = 1'b1;
              bitpos = 0;
            end
          end
        end
      end
      prev = line;
    end
  end

  // LCS answer stage model
  initial begin : resp
    int st, cnt, a, rl;
    ack = 1'b0; dataIn = 8'h00; st = 0; cnt = 0; a = 0; rl = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        st  = 0;
        ack = 1'b0;
      end else begin
        case (st)
          0: if (req) begin
               a = int'(addrLCS) % FL;
               addr_seq.push_back(int'(addrLCS));
               if (p_noack[a]) begin rl = 1; st = 3; end
               else begin cnt = p_delay[a]; st = 1; end
             end
          1: if (cnt == 0) begin ack = 1'b1; dataIn = p_data[a]; st = 2; end
             else cnt--;
          2: if (!req) begin cnt = p_hold[a]; st = 4; end
          3: if (req) rl++;
             else begin reqlen_q.push_back(rl); st = 0; end
          4: if (cnt == 0) begin ack = 1'b0; dataIn = 8'($urandom); st = 0; end
             else begin
               cnt--;
               if (hold_chk) begin
                 hold_seen++;
                 tests++;
                 if (req !== 1'b0 || int'(addrLCS) != a) begin
                   fails++;
                   $display("FAIL release_hold: req=%b addrLCS=%0d want req=0 addrLCS=%0d", req, addrLCS, a);
                 end
               end
             end
          default: st = 0;
        endcase
      end
    end
  end

  task automatic plan_random(input int dmax, input int hold);
    for (int k = 0; k < FL; k++) begin
      p_data[k]  = 8'($urandom);
      p_delay[k] = $urandom_range(0, dmax);
      p_noack[k] = 1'b0;
      p_hold[k]  = hold;
    end
  endtask

  task automatic run_frame(input bit extra_starts);
    int cyc;
    rx_q.delete(); par_q.delete(); stop_q.delete(); addr_seq.delete(); reqlen_q.delete();
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    err_at_start = errFlag;
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = extra_starts && ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      tests++; fails++;
      $display("FAIL frame_wait: frameDone not seen after %0d cycles", cyc);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    tests += 6;
    if (req !== 1'b0)       begin fails++; $display("FAIL reset_req: got %b want 0", req); end
    if (addrLCS !== 9'd0)   begin fails++; $display("FAIL reset_addr: got %0d want 0", addrLCS); end
    if (txd !== 1'b1)       begin fails++; $display("FAIL reset_txd: got %b want 1", txd); end
    if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (frameDone !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", frameDone); end
    if (errFlag !== 1'b0)   begin fails++; $display("FAIL reset_err: got %b want 0", errFlag); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_beats_start: busy=%b want 0", busy); end
  endtask

  task automatic test_frame();
    logic [7:0] exp;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        plan_random(0, 0);
        p_data[0] = 8'hA5; p_data[1] = 8'h3C; p_data[2] = 8'h00; p_data[3] = 8'hFF;
        for (int k = 0; k < FL; k++) p_delay[k] = 5;
      end else begin
        plan_random(20, $urandom_range(0, 3));
      end
      run_frame(it >= 2);
      tests += 5;
      if (rx_q.size() != FL)     begin fails++; $display("FAIL frame%0d_count: got %0d bytes want %0d", it, rx_q.size(), FL); end
      if (addr_seq.size() != FL) begin fails++; $display("FAIL frame%0d_reqs: got %0d reqs want %0d", it, addr_seq.size(), FL); end
      if (done_cnt != 1)         begin fails++; $display("FAIL frame%0d_done: got %0d pulses want 1", it, done_cnt); end
      if (errFlag !== 1'b0)      begin fails++; $display("FAIL frame%0d_err: got %b want 0", it, errFlag); end
      if (busy !== 1'b0)         begin fails++; $display("FAIL frame%0d_busy: got %b want 0", it, busy); end
      for (int k = 0; k < FL && k < rx_q.size(); k++) begin
        exp = p_noack[k] ? 8'hFF : p_data[k];
        tests += 2;
        if (rx_q[k] !== exp)    begin fails++; $display("FAIL frame%0d_byte%0d: got %h want %h", it, k, rx_q[k], exp); end
        if (stop_q[k] !== 1'b1) begin fails++; $display("FAIL frame%0d_stop%0d: got %b want 1", it, k, stop_q[k]); end
`ifdef LCS_PARITY_EN
        tests++;
        if (par_q[k] !== ^exp)  begin fails++; $display("FAIL frame%0d_par%0d: got %b want %b", it, k, par_q[k], ^exp); end
`endif
      end
      for (int k = 0; k < FL && k < addr_seq.size(); k++) begin
        tests++;
        if (addr_seq[k] != k) begin fails++; $display("FAIL frame%0d_addr%0d: got %0d want %0d", it, k, addr_seq[k], k); end
      end
    end
  endtask

  task automatic test_timeout();
    plan_random(10, 0);
    p_noack[2] = 1'b1;
    run_frame(1'b0);
    tests += 5;
    if (reqlen_q.size() != 1)                     begin fails++; $display("FAIL to_reqcount: got %0d want 1", reqlen_q.size()); end
    else if (reqlen_q[0] != AT)                   begin fails++; $display("FAIL to_reqlen: got %0d want %0d", reqlen_q[0], AT); end
    if (rx_q.size() != FL)                        begin fails++; $display("FAIL to_count: got %0d want %0d", rx_q.size(), FL); end
    else if (rx_q[2] !== 8'hFF || rx_q[3] !== p_data[3])
      begin fails++; $display("FAIL to_bytes: got %h %h want ff %h", rx_q[2], rx_q[3], p_data[3]); end
    if (errFlag !== 1'b1)                         begin fails++; $display("FAIL to_err: got %b want 1", errFlag); end
    if (done_cnt != 1)                            begin fails++; $display("FAIL to_done: got %0d want 1", done_cnt); end
    plan_random(10, 0);
    run_frame(1'b0);
    tests += 2;
    if (err_at_start !== 1'b0) begin fails++; $display("FAIL err_clear_on_start: got %b want 0", err_at_start); end
    if (errFlag !== 1'b0)      begin fails++; $display("FAIL err_after_clean: got %b want 0", errFlag); end
  endtask

  task automatic test_release_hold();
    plan_random(8, 30);
    hold_seen = 0;
    hold_chk  = 1'b1;
    run_frame(1'b0);
    hold_chk  = 1'b0;
    tests += 3;
    if (hold_seen != FL * 30) begin fails++; $display("FAIL hold_samples: got %0d want %0d", hold_seen, FL * 30); end
    if (rx_q.size() != FL || addr_seq.size() != FL)
      begin fails++; $display("FAIL hold_count: got %0d bytes %0d reqs want %0d", rx_q.size(), addr_seq.size(), FL); end
    else if (rx_q[1] !== p_data[1] || addr_seq[3] != 3)
      begin fails++; $display("FAIL hold_data: got %h/%0d want %h/3", rx_q[1], addr_seq[3], p_data[1]); end
    if (done_cnt != 1) begin fails++; $display("FAIL hold_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midframe();
    int cyc;
    plan_random(3, 0);
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(addrLCS == 9'd1 && bitpos == 5) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc >= 5000) begin fails++; $display("FAIL midrst_wait: data bit 3 of byte 1 not reached"); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests += 3;
    if (txd !== 1'b1)  begin fails++; $display("FAIL midrst_txd: got %b want 1", txd); end
    if (req !== 1'b0)  begin fails++; $display("FAIL midrst_req: got %b want 0", req); end
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    repeat (300) @(negedge clk);
    tests += 3;
    if (done_cnt != 0)      begin fails++; $display("FAIL midrst_nodone: got %0d pulses want 0", done_cnt); end
    if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_idle: busy=%b want 0", busy); end
    if (addrLCS !== 9'd0)   begin fails++; $display("FAIL midrst_addr: got %0d want 0", addrLCS); end
    run_frame(1'b0);
    tests++;
    if (rx_q.size() != FL || done_cnt != 1)
      begin fails++; $display("FAIL midrst_recover: got %0d bytes %0d done want %0d 1", rx_q.size(), done_cnt, FL); end
  endtask

  task automatic test_parity();
    plan_random(2, 0);
    p_data[0] = 8'h07;
    p_data[1] = 8'h03;
    run_frame(1'b0);
    tests++;
    if (rx_q.size() != FL) begin
      fails++; $display("FAIL par_count: got %0d want %0d", rx_q.size(), FL);
    end else begin
      tests += 4;
      if (rx_q[0] !== 8'h07)  begin fails++; $display("FAIL par_byte0: got %h want 07", rx_q[0]); end
      if (rx_q[1] !== 8'h03)  begin fails++; $display("FAIL par_byte1: got %h want 03", rx_q[1]); end
      if (stop_q[0] !== 1'b1) begin fails++; $display("FAIL par_stop0: got %b want 1", stop_q[0]); end
      if (stop_q[1] !== 1'b1) begin fails++; $display("FAIL par_stop1: got %b want 1", stop_q[1]); end
`ifdef LCS_PARITY_EN
      tests += 2;
      if (par_q[0] !== 1'b1) begin fails++; $display("FAIL par_bit0: got %b want 1", par_q[0]); end
      if (par_q[1] !== 1'b0) begin fails++; $display("FAIL par_bit1: got %b want 0", par_q[1]); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    for (int k = 0; k < FL; k++) begin
      p_data[k] = 8'h00; p_delay[k] = 0; p_noack[k] = 1'b0; p_hold[k] = 0;
    end
    test_reset();
    test_frame();
    test_timeout();
    test_release_hold();
    test_reset_midframe();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "time limit");
  end

endmodule
